// File: rtl/lfsr_pattern_packer.sv
// Packs the LFSR serial bit stream MSB-first into WIDTH-bit test vectors and
// hands them to the CUT harness over valid/ready, NUM_PATTERNS vectors per run.
module lfsr_pattern_packer #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned NUM_PATTERNS = 16,
   parameter int unsigned PCNT_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rnd,
   input  logic              pat_ready,
   output logic              pat_valid,
   output logic [WIDTH-1:0]  pattern,
   output logic [PCNT_W-1:0] pat_count,
   output logic              busy,
   output logic              done
);
   localparam int unsigned BCNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [WIDTH-2:0]  r_sr, w_sr_nxt;
   logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
   logic [WIDTH-1:0]  r_pattern, w_pattern_nxt;
   logic [PCNT_W-1:0] r_pcnt, w_pcnt_nxt;
   logic              r_valid, w_valid_nxt;
   logic              r_busy, r_done;
   logic [WIDTH-1:0]  w_shifted;
   logic [PCNT_W-1:0] w_pcnt_inc;

   // Only WIDTH-1 history bits are kept; the incoming bit completes the vector.
   assign w_shifted  = {r_sr, rnd};
   assign w_pcnt_inc = r_pcnt + PCNT_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_sr      <= '0;
         r_bcnt    <= '0;
         r_pattern <= '0;
         r_pcnt    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sr      <= w_sr_nxt;
         r_bcnt    <= w_bcnt_nxt;
         r_pattern <= w_pattern_nxt;
         r_pcnt    <= w_pcnt_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_HOLD);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_sr_nxt      = r_sr;
      w_bcnt_nxt    = r_bcnt;
      w_pattern_nxt = r_pattern;
      w_pcnt_nxt    = r_pcnt;
      w_valid_nxt   = r_valid;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_SHIFT;
               w_sr_nxt    = '0;
               w_bcnt_nxt  = '0;
               w_pcnt_nxt  = '0;
            end
         end
         S_SHIFT: begin
            w_sr_nxt = w_shifted[WIDTH-2:0];
            if (r_bcnt == BCNT_W'(WIDTH - 1)) begin
               w_pattern_nxt = w_shifted;
               w_valid_nxt   = 1'b1;
               w_bcnt_nxt    = '0;
               w_state_nxt   = S_HOLD;
            end else begin
               w_bcnt_nxt = r_bcnt + BCNT_W'(1);
            end
         end
         S_HOLD: begin
            // rnd is deliberately dropped here; the next vector starts after the handshake.
            if (pat_ready) begin
               w_valid_nxt = 1'b0;
               w_pcnt_nxt  = w_pcnt_inc;
               w_state_nxt = (w_pcnt_inc == PCNT_W'(NUM_PATTERNS)) ? S_DONE : S_SHIFT;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign pat_valid = r_valid;
   assign pattern   = r_pattern;
   assign pat_count = r_pcnt;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_lfsr_pattern_packer.sv
// Bench for lfsr_pattern_packer: a queue-based edge model of the packer for an
// 8-bit/3-pattern instance, plus directed checks on a 2-bit/1-pattern instance.
`timescale 1ns/1ps
module tb_lfsr_pattern_packer;
   localparam int unsigned W  = 8;
   localparam int unsigned N  = 3;
   localparam int unsigned CW = 8;
   localparam int unsigned OW = 3 + CW + W;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, rnd, pat_ready;
   logic          pat_valid, busy, done;
   logic [W-1:0]  pattern;
   logic [CW-1:0] pat_count;
   logic          s_start, s_rnd, s_ready;
   logic          s_valid, s_busy, s_done;
   logic [1:0]    s_pattern;
   logic [CW-1:0] s_count;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state
   bit            m_run, m_hold, m_done;
   bit            m_bits[$];
   logic [W-1:0]  m_pattern;
   int            m_count;

   wire [OW-1:0] w_obs = {pat_valid, busy, done, pat_count, pattern};

   always #5 clk = ~clk;

   lfsr_pattern_packer #(.WIDTH(W), .NUM_PATTERNS(N), .PCNT_W(CW)) u_dut (
      .clk(clk), .reset(reset), .start(start), .rnd(rnd), .pat_ready(pat_ready),
      .pat_valid(pat_valid), .pattern(pattern), .pat_count(pat_count),
      .busy(busy), .done(done)
   );

   lfsr_pattern_packer #(.WIDTH(2), .NUM_PATTERNS(1), .PCNT_W(CW)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .rnd(s_rnd), .pat_ready(s_ready),
      .pat_valid(s_valid), .pattern(s_pattern), .pat_count(s_count),
      .busy(s_busy), .done(s_done)
   );

   function automatic logic [OW-1:0] exp_vec();
      return {m_hold, m_run, m_done, CW'(m_count), m_pattern};
   endfunction

   task automatic model_reset();
      m_run = 0; m_hold = 0; m_done = 0; m_count = 0; m_pattern = '0;
      m_bits.delete();
   endtask

   // One rising edge as the packer should see it, expressed with a bit queue.
   task automatic model_edge();
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_done = 0; m_count = 0;
            m_bits.delete();
         end
      end else if (!m_hold) begin
         m_bits.push_back(rnd);
         if (m_bits.size() == int'(W)) begin
            m_pattern = '0;
            foreach (m_bits[i]) m_pattern = {m_pattern[W-2:0], m_bits[i]};
            m_hold = 1;
            m_bits.delete();
         end
      end else if (pat_ready) begin
         m_hold = 0;
         m_count++;
         if (m_count == int'(N)) begin
            m_run = 0; m_done = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 0; rnd = 0; pat_ready = 0;
      s_start = 0; s_rnd = 0; s_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (w_obs !== '0) $display("FAIL reset_init: got %h expected 0", w_obs); else n_pass++;
      n_total++;
      if ({s_valid, s_busy, s_done, s_count, s_pattern} !== '0)
         $display("FAIL reset_init_small: got %h expected 0", {s_valid, s_busy, s_done, s_count, s_pattern});
      else n_pass++;
      reset = 1'b1;
      start = 1; tick(); start = 0;
      for (int i = 0; i < int'(W); i++) begin
         rnd = 1'($urandom); tick();
      end
      n_total++;
      if (w_obs !== exp_vec() || pat_valid !== 1'b1)
         $display("FAIL reach_hold: got %h expected %h", w_obs, exp_vec());
      else n_pass++;
      // Reset between edges must clear everything without waiting for a clock.
      #2; reset = 1'b0; #1;
      model_reset();
      n_total++;
      if (w_obs !== '0) $display("FAIL reset_async: got %h expected 0", w_obs); else n_pass++;
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         rnd = 1'($urandom); pat_ready = 1'($urandom);
         tick();
         n_total++;
         if (w_obs !== exp_vec() || w_obs !== '0)
            $display("FAIL reset_idle cyc %0d: got %h expected 0", c, w_obs);
         else n_pass++;
      end
   endtask

   task automatic test_basic_pack();
      logic [7:0] bits;
      bits = 8'hB2;
      pat_ready = 1; start = 1; tick(); start = 0;
      for (int i = 0; i < 8; i++) begin
         rnd = bits[7-i];
         tick();
         n_total++;
         if (w_obs !== exp_vec()) $display("FAIL basic_model bit %0d: got %h expected %h", i, w_obs, exp_vec());
         else n_pass++;
      end
      n_total++;
      if (pat_valid !== 1'b1 || pattern !== 8'hB2 || busy !== 1'b1)
         $display("FAIL basic_capture: got valid=%b pattern=%h busy=%b expected 1/b2/1", pat_valid, pattern, busy);
      else n_pass++;
      tick();
      n_total++;
      if (pat_valid !== 1'b0 || pat_count !== 8'd1 || pattern !== 8'hB2)
         $display("FAIL basic_handshake: got valid=%b count=%0d pattern=%h expected 0/1/b2", pat_valid, pat_count, pattern);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] held;
      pat_ready = 0;
      for (int i = 0; i < int'(W); i++) begin
         rnd = 1'($urandom); tick();
      end
      held = m_pattern;
      for (int c = 0; c < 5; c++) begin
         rnd = ~rnd;
         tick();
         n_total++;
         if (w_obs !== exp_vec() || pattern !== held || pat_valid !== 1'b1)
            $display("FAIL bp_hold cyc %0d: got %h expected %h", c, w_obs, exp_vec());
         else n_pass++;
      end
      pat_ready = 1; rnd = 0; tick();
      n_total++;
      if (pat_count !== 8'd2 || pat_valid !== 1'b0)
         $display("FAIL bp_release: got count=%0d valid=%b expected 2/0", pat_count, pat_valid);
      else n_pass++;
      rnd = 1;
      for (int i = 0; i < int'(W); i++) tick();
      n_total++;
      if (pattern !== 8'hFF || pat_valid !== 1'b1 || w_obs !== exp_vec())
         $display("FAIL bp_all_ones: got %h expected pattern ff", w_obs);
      else n_pass++;
      tick();
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || pat_count !== 8'd3 || w_obs !== exp_vec())
         $display("FAIL bp_done: got %h expected %h", w_obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_full_run();
      int hs;
      hs = 0;
      pat_ready = 1; start = 1; tick(); start = 0;
      n_total++;
      if (done !== 1'b0 || pat_count !== 8'd0 || busy !== 1'b1)
         $display("FAIL restart_from_done: got done=%b count=%0d busy=%b expected 0/0/1", done, pat_count, busy);
      else n_pass++;
      for (int c = 1; c <= int'(N * (W + 1)); c++) begin
         if (pat_valid) hs++;
         rnd = 1'($urandom);
         tick();
         n_total++;
         if (w_obs !== exp_vec()) $display("FAIL full_model cyc %0d: got %h expected %h", c, w_obs, exp_vec());
         else n_pass++;
         if (c == int'(N * (W + 1)) - 1) begin
            n_total++;
            if (done !== 1'b0) $display("FAIL full_early_done: got done=%b expected 0", done); else n_pass++;
         end
      end
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || pat_count !== CW'(N) || hs != int'(N))
         $display("FAIL full_end: got done=%b busy=%b count=%0d handshakes=%0d expected 1/0/%0d/%0d",
                  done, busy, pat_count, hs, N, N);
      else n_pass++;
   endtask

   task automatic test_start_ignored();
      pat_ready = 1; start = 1; tick();
      for (int c = 1; c <= int'(N * (W + 1)); c++) begin
         start = 1'($urandom); rnd = 1'($urandom);
         tick();
         n_total++;
         if (w_obs !== exp_vec()) $display("FAIL start_ign cyc %0d: got %h expected %h", c, w_obs, exp_vec());
         else n_pass++;
      end
      n_total++;
      if (done !== 1'b1 || pat_count !== CW'(N))
         $display("FAIL start_ign_end: got done=%b count=%0d expected 1/%0d", done, pat_count, N);
      else n_pass++;
      start = 0; tick();
      n_total++;
      if (w_obs !== exp_vec() || done !== 1'b1)
         $display("FAIL done_hold: got %h expected %h", w_obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         start     = ($urandom_range(0, 15) == 0);
         rnd       = 1'($urandom);
         pat_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b0; #1;
            model_reset();
            n_total++;
            if (w_obs !== '0) $display("FAIL rand_reset cyc %0d: got %h expected 0", c, w_obs); else n_pass++;
            reset = 1'b1;
         end
         tick();
         n_total++;
         if (w_obs !== exp_vec()) $display("FAIL rand cyc %0d: got %h expected %h", c, w_obs, exp_vec());
         else n_pass++;
      end
      start = 0; pat_ready = 0;
   endtask

   task automatic test_min_config();
      s_ready = 1; s_start = 1; tick(); s_start = 0;
      n_total++;
      if (s_busy !== 1'b1 || s_done !== 1'b0) $display("FAIL min_start: got busy=%b done=%b expected 1/0", s_busy, s_done);
      else n_pass++;
      s_rnd = 1; tick();
      s_rnd = 0; tick();
      n_total++;
      if (s_valid !== 1'b1 || s_pattern !== 2'b10 || s_done !== 1'b0)
         $display("FAIL min_capture: got valid=%b pattern=%b done=%b expected 1/10/0", s_valid, s_pattern, s_done);
      else n_pass++;
      tick();
      n_total++;
      if (s_done !== 1'b1 || s_busy !== 1'b0 || s_count !== 8'd1 || s_valid !== 1'b0 || s_pattern !== 2'b10)
         $display("FAIL min_done: got done=%b busy=%b count=%0d valid=%b expected 1/0/1/0", s_done, s_busy, s_count, s_valid);
      else n_pass++;
      s_ready = 0;
   endtask

   initial begin
      test_reset();
      test_basic_pack();
      test_backpressure();
      test_full_run();
      test_start_ignored();
      test_random();
      test_min_config();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
